// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Holds the sequencing FSM encoding and the register-zero constant.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF  = 5;
    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

    // x0 is hardwired to zero, so it can never create a true dependency
    localparam int REG_X0 = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the performance-debug event counts.
// Sticks at all-ones rather than wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes,
// data-memory wait freezes and a timeout lock on a hung memory.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  mem_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ctrl_mux_sel,
    output logic                  pipe_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      wait_cnt_total,
    output logic [1:0]            dbg_state
);

    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;

    logic hold;
    logic lu;
    logic active;
    logic bubble_inc, flush_inc, wait_inc;

    assign hold   = dmem_req & ~dmem_ready;
    assign lu     = ex_memread & (ex_rd != REG_ADDR_W'(REG_X0)) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign active = (state_q != ERR);

    // Events are only counted while the controller is live; a locked ERR
    // pipeline records nothing further.
    assign wait_inc   = active & hold;
    assign flush_inc  = active & ~hold & mem_branch_taken;
    assign bubble_inc = active & ~hold & ~mem_branch_taken & lu;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (hold) begin
                    state_d = MEM_WAIT;
                    wait_d  = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (hold) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = ERR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Output priority: reset > freeze (hold or ERR) > branch > load-use > normal
    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ctrl_mux_sel = 1'b0;
        pipe_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        if (!rst_n) begin
            ctrl_mux_sel = 1'b1;
        end else if (!active || hold) begin
            ctrl_mux_sel = 1'b0;
        end else if (mem_branch_taken) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ctrl_mux_sel = 1'b1;
            pipe_en      = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
        end else if (lu) begin
            ctrl_mux_sel = 1'b1;
            pipe_en      = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_en    = 1'b1;
        end
    end

    assign mem_err   = (state_q == ERR);
    assign dbg_state = state_q;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .count (wait_cnt_total)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int RW   = 5;
    localparam int MT   = 4;
    localparam int CW   = 2;
    localparam int SW   = 3 + 3 * CW;
    localparam int MAXC = (1 << CW) - 1;

    // {pc_write, ifid_write, ctrl_mux_sel, pipe_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [6:0] C_RST  = 7'b0010000;
    localparam logic [6:0] C_HOLD = 7'b0000000;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_LU   = 7'b0011000;
    localparam logic [6:0] C_NORM = 7'b1101000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_uses_rs2 = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0;
    logic          dmem_req = 1'b0, dmem_ready = 1'b0;
    logic          pc_write, ifid_write, ctrl_mux_sel, pipe_en;
    logic          ifid_flush, idex_flush, exmem_flush, mem_err;
    logic [CW-1:0] bubble_cnt, flush_cnt, wait_cnt_total;
    logic [1:0]    dbg_state;

    logic [6:0]    obs_ctrl;
    logic [SW-1:0] obs_stat;

    // clock/reset block
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd            (ex_rd),
        .ex_memread       (ex_memread),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ctrl_mux_sel     (ctrl_mux_sel),
        .pipe_en          (pipe_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .mem_err          (mem_err),
        .bubble_cnt       (bubble_cnt),
        .flush_cnt        (flush_cnt),
        .wait_cnt_total   (wait_cnt_total),
        .dbg_state        (dbg_state)
    );

    assign obs_ctrl = {pc_write, ifid_write, ctrl_mux_sel, pipe_en, ifid_flush, idex_flush, exmem_flush};
    assign obs_stat = {mem_err, dbg_state, bubble_cnt, flush_cnt, wait_cnt_total};

    int total = 0;
    int bad   = 0;

    // behavioural model: consecutive-hold run length, lock flag, event tallies
    int m_holds = 0;
    bit m_err   = 1'b0;
    int m_bub   = 0;
    int m_fl    = 0;
    int m_wt    = 0;

    logic [6:0]    exp_q[$];
    logic [6:0]    ctrl_seen, ctrl_exp;
    logic [SW-1:0] stat_seen, stat_exp;

    function automatic bit model_lu();
        return ex_memread && (ex_rd != 0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

    function automatic logic [6:0] model_ctrl();
        if (!rst_n) return C_RST;
        if (m_err || (dmem_req && !dmem_ready)) return C_HOLD;
        if (mem_branch_taken) return C_BR;
        if (model_lu()) return C_LU;
        return C_NORM;
    endfunction

    function automatic logic [SW-1:0] model_stat();
        logic [1:0] st;
        if (m_err) st = 2'(ERR);
        else if (m_holds > 0) st = 2'(MEM_WAIT);
        else st = 2'(RUN);
        return {m_err, st, CW'(m_bub), CW'(m_fl), CW'(m_wt)};
    endfunction

    task automatic model_clock();
        if (m_err) return;
        if (dmem_req && !dmem_ready) begin
            if (m_wt < MAXC) m_wt++;
            m_holds++;
            if (m_holds == MT) m_err = 1'b1;
        end else begin
            m_holds = 0;
            if (mem_branch_taken) begin
                if (m_fl < MAXC) m_fl++;
            end else if (model_lu()) begin
                if (m_bub < MAXC) m_bub++;
            end
        end
    endtask

    task automatic model_reset();
        m_holds = 0; m_err = 1'b0; m_bub = 0; m_fl = 0; m_wt = 0;
    endtask

    // driver tasks
    task automatic set_in(input logic mr, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                          input logic [RW-1:0] rs2, input logic u2, input logic br,
                          input logic req, input logic rdy);
        ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs2 = u2; mem_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    // Called at a falling edge; samples control outputs mid-low-phase,
    // advances one rising edge, then samples registered status.
    task automatic tick();
        #1;
        ctrl_seen = obs_ctrl;
        ctrl_exp  = model_ctrl();
        @(posedge clk);
        model_clock();
        #1;
        stat_seen = obs_stat;
        stat_exp  = model_stat();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        total++;
        if (obs_ctrl !== C_RST) begin
            bad++; $display("FAIL reset_ctrl: got %b want %b", obs_ctrl, C_RST);
        end
        total++;
        if (obs_stat !== '0) begin
            bad++; $display("FAIL reset_stat: got %h want 0", obs_stat);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ctrl_seen !== C_LU) begin
            bad++; $display("FAIL lu_ctrl: got %b want %b", ctrl_seen, C_LU);
        end
        total++;
        if (bubble_cnt !== CW'(1)) begin
            bad++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt);
        end
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ctrl_seen !== C_NORM) begin
            bad++; $display("FAIL lu_x0_ctrl: got %b want %b", ctrl_seen, C_NORM);
        end
        total++;
        if (bubble_cnt !== CW'(1)) begin
            bad++; $display("FAIL lu_x0_bubble_cnt: got %0d want 1", bubble_cnt);
        end
    endtask

    task automatic test_rs2_gating();
        set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ctrl_seen !== C_NORM) begin
            bad++; $display("FAIL rs2_unused_ctrl: got %b want %b", ctrl_seen, C_NORM);
        end
        set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ctrl_seen !== C_LU) begin
            bad++; $display("FAIL rs2_used_ctrl: got %b want %b", ctrl_seen, C_LU);
        end
        total++;
        if (bubble_cnt !== CW'(2)) begin
            bad++; $display("FAIL rs2_bubble_cnt: got %0d want 2", bubble_cnt);
        end
    endtask

    task automatic test_branch_lu();
        apply_reset();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (ctrl_seen !== C_BR) begin
            bad++; $display("FAIL br_lu_ctrl: got %b want %b", ctrl_seen, C_BR);
        end
        total++;
        if ({bubble_cnt, flush_cnt} !== {CW'(0), CW'(1)}) begin
            bad++; $display("FAIL br_lu_counts: got bub=%0d fl=%0d want bub=0 fl=1", bubble_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 3; c++) begin
                set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, pass[0], 1'b1, 1'b0);
                tick();
                total++;
                if (ctrl_seen !== C_HOLD) begin
                    bad++; $display("FAIL wait_hold_ctrl p%0d c%0d: got %b want %b", pass, c, ctrl_seen, C_HOLD);
                end
                total++;
                if (dbg_state !== 2'(MEM_WAIT)) begin
                    bad++; $display("FAIL wait_state p%0d c%0d: got %0d want %0d", pass, c, dbg_state, MEM_WAIT);
                end
            end
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, pass[0], 1'b1, 1'b1);
            tick();
            total++;
            if (ctrl_seen !== (pass == 0 ? C_NORM : C_BR)) begin
                bad++; $display("FAIL wait_release_ctrl p%0d: got %b", pass, ctrl_seen);
            end
            total++;
            if ({dbg_state, wait_cnt_total, flush_cnt} !== {2'(RUN), CW'(3), CW'(pass)}) begin
                bad++; $display("FAIL wait_release_stat p%0d: got st=%0d wt=%0d fl=%0d want st=0 wt=3 fl=%0d",
                                pass, dbg_state, wait_cnt_total, flush_cnt, pass);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int c = 1; c <= MT; c++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            total++;
            if ({mem_err, dbg_state} !== (c == MT ? {1'b1, 2'(ERR)} : {1'b0, 2'(MEM_WAIT)})) begin
                bad++; $display("FAIL timeout_state c%0d: got err=%b st=%0d", c, mem_err, dbg_state);
            end
        end
        set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        total++;
        if (ctrl_seen !== C_HOLD) begin
            bad++; $display("FAIL err_frozen_ctrl: got %b want %b", ctrl_seen, C_HOLD);
        end
        total++;
        if ({mem_err, dbg_state} !== {1'b1, 2'(ERR)}) begin
            bad++; $display("FAIL err_sticky: got err=%b st=%0d want err=1 st=2", mem_err, dbg_state);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({obs_ctrl, obs_stat} !== {C_RST, SW'(0)}) begin
            bad++; $display("FAIL err_reset: got ctrl=%b stat=%h want ctrl=%b stat=0", obs_ctrl, obs_stat, C_RST);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b1, 5'd12, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            total++;
            if ({ctrl_seen, bubble_cnt} !== {C_LU, CW'(i > MAXC ? MAXC : i)}) begin
                bad++; $display("FAIL sat_bubble i%0d: got ctrl=%b cnt=%0d", i, ctrl_seen, bubble_cnt);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_err && ($urandom_range(0, 3) == 0)) apply_reset();
            set_in(1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                   RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1));
            tick();
            exp_q.push_back(ctrl_exp);
            total++;
            if (ctrl_seen !== exp_q.pop_front()) begin
                bad++; $display("FAIL rand_ctrl n%0d: got %b want %b", n, ctrl_seen, ctrl_exp);
            end
            total++;
            if (stat_seen !== stat_exp) begin
                bad++; $display("FAIL rand_stat n%0d: got %h want %h", n, stat_seen, stat_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rs2_gating();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates the bubble-select for the ID-stage control mux, PC/IF-ID write enables, per-register flushes and a global pipeline enable. It handles three cases: load-use stalls, taken-branch flushes and data-memory wait states. A timeout FSM locks the pipeline on a hung memory. Saturating event counters are exported for performance debug.

Parameters:
REG_ADDR_W, 5, register-file address width
MEM_TIMEOUT, 64, max consecutive dmem wait cycles before error (>=2)
CNT_W, 16, width of each saturating event counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  source reg 1 of instruction in ID
id_rs2  in  REG_ADDR_W  source reg 2 of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
ex_rd  in  REG_ADDR_W  destination reg of instruction in EX
ex_memread  in  1  EX instruction is a load (ID/EX MemRead)
mem_branch_taken  in  1  Branch & zero resolved in MEM stage
dmem_req  in  1  MEM stage is accessing data memory
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ctrl_mux_sel  out  1  drives control-mux sel: 1 = zero all ID control fields
pipe_en  out  1  global enable for ID/EX, EX/MEM, MEM/WB
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  clear ID/EX control fields
exmem_flush  out  1  clear EX/MEM control fields
mem_err  out  1  sticky: memory timeout occurred
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating
wait_cnt_total  out  CNT_W  dmem wait cycles, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERR. Reset enters RUN. All counters are 0 and mem_err is 0 at reset.
- While rst_n=0: pc_write=0, ifid_write=0, pipe_en=0, ctrl_mux_sel=1, all flushes=0.
- Combinational terms:
  - hold = dmem_req & ~dmem_ready.
  - lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority each cycle in RUN/MEM_WAIT: hold > mem_branch_taken > lu > normal.
  - hold: pc_write=0, ifid_write=0, pipe_en=0, ctrl_mux_sel=0, no flushes. All stages freeze; a pending branch stays in MEM and resolves on release.
  - branch (no hold): pc_write=1 (target), ifid_write=1, pipe_en=1, ctrl_mux_sel=1, ifid_flush=idex_flush=exmem_flush=1. lu is ignored because the younger instructions are discarded. flush_cnt+1.
  - lu (no hold, no branch): pc_write=0, ifid_write=0, pipe_en=1, ctrl_mux_sel=1, no flushes. This gives exactly 1 bubble; next cycle the load is in MEM and lu is deasserted. bubble_cnt+1.
  - normal: pc_write=ifid_write=pipe_en=1, ctrl_mux_sel=0, flushes 0.
- Reg x0 never causes a stall.
- FSM and wait timing:
  - RUN->MEM_WAIT when hold. Internal wait counter loads 1.
  - MEM_WAIT stays while hold, incrementing the wait counter. It returns to RUN in the cycle dmem_ready=1; that cycle is evaluated with normal priority, so the pipeline advances that same cycle.
  - MEM_WAIT->ERR when hold and the wait counter == MEM_TIMEOUT-1. The timeout therefore fires on the MEM_TIMEOUT-th consecutive hold cycle.
  - wait_cnt_total+1 on every hold cycle.
- ERR: mem_err=1. Outputs are as hold (frozen) regardless of inputs. ERR is left only by reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-stall or mid-ERR returns to RUN with counters cleared; no partial state is retained.

Decomposition:
- hazard_pkg:
  - state enum {RUN, MEM_WAIT, ERR}.
  - REG_X0 = 0.
  - Default REG_ADDR_W and CNT_W constants.
- Sub-module sat_counter (param W; clk, rst_n, inc, count): instantiated 3x for the event counters.
- Hazard compare and priority logic stay in hazard_stall_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle -> ctrl_mux_sel=1, pc_write=0, ifid_write=0 that cycle; bubble_cnt=1. Repeat with ex_rd=0 -> no stall.
- rs2 gating: ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; with id_uses_rs2=1 -> stall.
- Branch + load-use same cycle: mem_branch_taken=1 and lu true -> all three flushes=1, pc_write=1, bubble_cnt unchanged, flush_cnt=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready -> pipe_en=0 for exactly 3 cycles; state MEM_WAIT->RUN; wait_cnt_total=3. Repeat with branch asserted throughout -> flush fires only on the ready cycle.
- Timeout: MEM_TIMEOUT=4, hold held 4 cycles -> ERR entered, mem_err=1, pipeline frozen even after dmem_ready=1. Assert rst_n=0 mid-ERR -> RUN, mem_err=0, counters 0.
- Saturation: CNT_W=2, force 5 load-use stalls -> bubble_cnt stays 3.
